// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer: combinational lookup, one resolved-branch update per cycle.
// Optional same-cycle forwarding of an update to a matching lookup: define BTB_BYPASS_EN.
module btb_set_assoc #(
  parameter int SETS  = 64,
  parameter int WAYS  = 2,
  parameter int CTR_W = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        flush
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int VW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [VW-1:0]    VIC_LAST = VW'(WAYS - 1);

  logic             valid_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q    [SETS][WAYS];
  logic [CTR_W-1:0] ctr_q    [SETS][WAYS];
  logic [31:0]      tgt_q    [SETS][WAYS];
  logic [VW-1:0]    victim_q [SETS];

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;

  logic             arr_hit;
  logic [VW-1:0]    arr_way;
  logic             u_hit, inv_found;
  logic [VW-1:0]    u_way, inv_way, alloc_way, vic_next;
  logic [CTR_W-1:0] u_ctr, u_ctr_next;
  logic [31:0]      u_tgt;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign l_idx = lookup_pc[IDX_W+1:2];
  assign l_tag = lookup_pc[31:IDX_W+2];
  assign u_idx = update_pc[IDX_W+1:2];
  assign u_tag = update_pc[31:IDX_W+2];

  // Descending scans so the lowest-numbered qualifying way is the one that sticks.
  always_comb begin
    arr_hit   = 1'b0;
    arr_way   = '0;
    u_hit     = 1'b0;
    u_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag)) begin
        arr_hit = 1'b1;
        arr_way = VW'(w);
      end
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit = 1'b1;
        u_way = VW'(w);
      end
      if (!valid_q[u_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = VW'(w);
      end
    end
  end

  always_comb begin
    u_ctr      = ctr_q[u_idx][u_way];
    u_tgt      = tgt_q[u_idx][u_way];
    u_ctr_next = u_ctr;
    if (update_taken) begin
      if (u_ctr != CTR_MAX) u_ctr_next = u_ctr + 1'b1;
    end else begin
      if (u_ctr != '0) u_ctr_next = u_ctr - 1'b1;
    end
    alloc_way = inv_found ? inv_way : victim_q[u_idx];
    vic_next  = (victim_q[u_idx] == VIC_LAST) ? '0 : victim_q[u_idx] + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        victim_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          ctr_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
        end
      end
    end else if (flush) begin
      // Counters and targets are left alone; only visibility is revoked.
      for (int s = 0; s < SETS; s++) begin
        victim_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (update_en) begin
      if (u_hit) begin
        ctr_q[u_idx][u_way] <= u_ctr_next;
        if (update_taken) tgt_q[u_idx][u_way] <= update_target;
      end else if (update_taken) begin
        valid_q[u_idx][alloc_way] <= 1'b1;
        tag_q[u_idx][alloc_way]   <= u_tag;
        ctr_q[u_idx][alloc_way]   <= CTR_WEAK;
        tgt_q[u_idx][alloc_way]   <= update_target;
        if (!inv_found) victim_q[u_idx] <= vic_next;
      end
    end
  end

  always_comb begin
    hit         = arr_hit;
    pred_taken  = arr_hit & ctr_q[l_idx][arr_way][CTR_W-1];
    pred_target = arr_hit ? tgt_q[l_idx][arr_way] : 32'h0;
`ifdef BTB_BYPASS_EN
    if (update_en && !flush && (update_pc[31:2] == lookup_pc[31:2]) &&
        (u_hit || update_taken)) begin
      hit         = 1'b1;
      pred_taken  = u_hit ? u_ctr_next[CTR_W-1] : 1'b1;
      pred_target = update_taken ? update_target : u_tgt;
    end
`endif
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc (default SETS=64, WAYS=2, CTR_W=2) with an expectation queue.
module tb_btb_set_assoc;

  logic        CLK;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        flush;

  btb_set_assoc dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .hit(hit),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .flush(flush)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string       tag;
    logic [33:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Expected {hit, pred_taken, pred_target} queued with the lookup, popped once outputs settle.
  task automatic chk_now(input string tag, input logic [31:0] pc,
                         input logic h, input logic t, input logic [31:0] tg);
    sb_item_t    it;
    logic [33:0] obs;
    lookup_pc = pc;
    sb.push_back('{tag, {h, t, tg}});
    #1;
    it  = sb.pop_front();
    obs = {hit, pred_taken, pred_target};
    n_checks++;
    assert (obs === it.exp) else begin
      n_fail++;
      $error("FAIL %s: observed hit/taken/target %b/%b/%h expected %b/%b/%h",
             it.tag, obs[33], obs[32], obs[31:0], it.exp[33], it.exp[32], it.exp[31:0]);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] pc,
                     input logic h, input logic t, input logic [31:0] tg);
    @(negedge CLK);
    chk_now(tag, pc, h, t, tg);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tg,
                     input logic en, input logic fl);
    @(negedge CLK);
    update_en     = en;
    update_pc     = pc;
    update_taken  = taken;
    update_target = tg;
    flush         = fl;
    @(posedge CLK);
    #1;
    update_en = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; lookup_pc = '0; update_en = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_target = '0; flush = 1'b0;

    chk_now("in_reset", 32'h104, 1'b0, 1'b0, 32'h0);
    #12 nRST = 1'b1;
    chk("after_reset", 32'h104, 1'b0, 1'b0, 32'h0);

    upd(32'h104, 1'b1, 32'h200, 1'b1, 1'b0);
    chk("alloc_104", 32'h104, 1'b1, 1'b1, 32'h200);
    upd(32'h104, 1'b0, 32'h999, 1'b1, 1'b0);
    chk("nt_ctr01", 32'h104, 1'b1, 1'b0, 32'h200);
    upd(32'h104, 1'b0, 32'h999, 1'b1, 1'b0);
    chk("nt_ctr00", 32'h104, 1'b1, 1'b0, 32'h200);
    upd(32'h104, 1'b0, 32'h999, 1'b1, 1'b0);
    chk("nt_sat0", 32'h104, 1'b1, 1'b0, 32'h200);
    upd(32'h104, 1'b1, 32'h210, 1'b1, 1'b0);
    chk("t_ctr01", 32'h104, 1'b1, 1'b0, 32'h210);
    // 01 -> 10 -> 11 -> 11, then one not-taken leaves 10 (still predicts taken).
    upd(32'h104, 1'b1, 32'h220, 1'b1, 1'b0);
    upd(32'h104, 1'b1, 32'h220, 1'b1, 1'b0);
    upd(32'h104, 1'b1, 32'h220, 1'b1, 1'b0);
    chk("t_sat3", 32'h104, 1'b1, 1'b1, 32'h220);
    upd(32'h104, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("sat_then_nt", 32'h104, 1'b1, 1'b1, 32'h220);

    upd(32'h108, 1'b0, 32'h555, 1'b1, 1'b0);
    chk("nt_miss_noalloc", 32'h108, 1'b0, 1'b0, 32'h0);
    chk("other_set_kept", 32'h104, 1'b1, 1'b1, 32'h220);

    upd(32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("flush_clears", 32'h104, 1'b0, 1'b0, 32'h0);

    upd(32'h104, 1'b1, 32'hA0, 1'b1, 1'b0);
    upd(32'h204, 1'b1, 32'hB0, 1'b1, 1'b0);
    chk("way0_104", 32'h104, 1'b1, 1'b1, 32'hA0);
    chk("way1_204", 32'h204, 1'b1, 1'b1, 32'hB0);
    upd(32'h304, 1'b1, 32'hC0, 1'b1, 1'b0);
    chk("evict_104", 32'h104, 1'b0, 1'b0, 32'h0);
    chk("keep_204", 32'h204, 1'b1, 1'b1, 32'hB0);
    chk("new_304", 32'h304, 1'b1, 1'b1, 32'hC0);
    upd(32'h404, 1'b1, 32'hD0, 1'b1, 1'b0);
    chk("evict_204", 32'h204, 1'b0, 1'b0, 32'h0);
    chk("keep_304", 32'h304, 1'b1, 1'b1, 32'hC0);
    chk("new_404", 32'h404, 1'b1, 1'b1, 32'hD0);

    // Flush wins over a same-cycle update; the flush cycle still shows old contents.
    @(negedge CLK);
    update_en = 1'b1; update_pc = 32'h504; update_taken = 1'b1;
    update_target = 32'hE0; flush = 1'b1;
    chk_now("flush_cycle_old", 32'h304, 1'b1, 1'b1, 32'hC0);
    @(posedge CLK);
    #1;
    update_en = 1'b0; flush = 1'b0;
    chk("flush_304", 32'h304, 1'b0, 1'b0, 32'h0);
    chk("flush_drop_504", 32'h504, 1'b0, 1'b0, 32'h0);

    // Victim pointer restarts at way0 after flush.
    upd(32'h104, 1'b1, 32'hA1, 1'b1, 1'b0);
    upd(32'h204, 1'b1, 32'hB1, 1'b1, 1'b0);
    upd(32'h304, 1'b1, 32'hC1, 1'b1, 1'b0);
    chk("vic_reset_104", 32'h104, 1'b0, 1'b0, 32'h0);
    chk("vic_reset_204", 32'h204, 1'b1, 1'b1, 32'hB1);

    upd(32'h108, 1'b1, 32'hF0, 1'b1, 1'b0);
    chk("alloc_108", 32'h108, 1'b1, 1'b1, 32'hF0);

    @(negedge CLK);
    nRST = 1'b0;
    chk_now("async_reset", 32'h108, 1'b0, 1'b0, 32'h0);
    #2 nRST = 1'b1;
    chk("post_reset_204", 32'h204, 1'b0, 1'b0, 32'h0);

    @(negedge CLK);
    update_en = 1'b1; update_pc = 32'h104; update_taken = 1'b1;
    update_target = 32'h300; flush = 1'b0;
`ifdef BTB_BYPASS_EN
    chk_now("same_cycle_bypass", 32'h104, 1'b1, 1'b1, 32'h300);
`else
    chk_now("same_cycle_nobypass", 32'h104, 1'b0, 1'b0, 32'h0);
`endif
    @(posedge CLK);
    #1;
    update_en = 1'b0;
    chk("next_cycle_visible", 32'h104, 1'b1, 1'b1, 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
